// File: rtl/qspi_line_prefetcher.sv
// Next-line prefetch stage between the XIP cache miss path and the QSPI
// flash line reader. Demand fetches pass through; after each delivery the
// following 16-byte line is fetched into a one-entry prefetch buffer.
module qspi_line_prefetcher #(
  parameter int LINE_SIZE = 128,
  parameter int AW        = 24
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 req_rd,
  input  logic [AW-1:0]        req_addr,
  output logic                 req_done,
  output logic [LINE_SIZE-1:0] req_line,
  input  logic                 pf_enable,
  input  logic                 inval,
  output logic                 pf_hit,
  output logic                 fr_rd,
  output logic [AW-1:0]        fr_addr,
  input  logic                 fr_done,
  input  logic [LINE_SIZE-1:0] fr_line
);

  localparam int TW = AW - 4;  // line-index width

  typedef enum logic [1:0] {IDLE, DEMAND, PREFETCH, PF_PEND} state_e;

  state_e               state_q, state_d;
  logic                 pf_valid_q, pf_valid_d;
  logic                 pf_kill_q, pf_kill_d;
  logic [TW-1:0]        pf_tag_q, pf_tag_d;
  logic [LINE_SIZE-1:0] pf_data_q, pf_data_d;
  logic [TW-1:0]        pend_tag_q, pend_tag_d;
  logic                 req_done_q, req_done_d;
  logic                 pf_hit_q, pf_hit_d;
  logic [LINE_SIZE-1:0] req_line_q, req_line_d;
  logic                 fr_rd_q, fr_rd_d;
  logic [TW-1:0]        fr_tag_q, fr_tag_d;

  logic [TW-1:0] req_tag;
  logic [TW-1:0] res_tag;
  logic          idle_hit;
  logic          in_pf;
  logic          kill;
  logic          resolve;
  logic          res_hit;
  logic          unused_low_bits;

  assign unused_low_bits = ^req_addr[3:0];

  // Request decode: buffer hit, prefetch discard and pending-request resolution.
  always_comb begin
    req_tag  = req_addr[AW-1:4];
    idle_hit = pf_valid_q && (pf_tag_q == req_tag) && !inval;
    in_pf    = (state_q == PREFETCH) || (state_q == PF_PEND);
    kill     = pf_kill_q || inval;
    resolve  = fr_done && ((state_q == PF_PEND) || ((state_q == PREFETCH) && req_rd));
    res_tag  = (state_q == PF_PEND) ? pend_tag_q : req_tag;
    res_hit  = !kill && (res_tag == fr_tag_q);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (req_rd) state_d = idle_hit ? (pf_enable ? PREFETCH : IDLE) : DEMAND;
      DEMAND:   if (fr_done) state_d = pf_enable ? PREFETCH : IDLE;
      PREFETCH: begin
        if (resolve)      state_d = res_hit ? (pf_enable ? PREFETCH : IDLE) : DEMAND;
        else if (fr_done) state_d = IDLE;
        else if (req_rd)  state_d = PF_PEND;
      end
      PF_PEND:  if (resolve) state_d = res_hit ? (pf_enable ? PREFETCH : IDLE) : DEMAND;
      default:  state_d = IDLE;
    endcase
  end

  // Datapath and registered-output updates for each state/event.
  always_comb begin
    // NOTE: every variable gets a default here so no path infers a latch.
    pf_valid_d = pf_valid_q && !inval;
    pf_kill_d  = pf_kill_q || (in_pf && inval);
    pf_tag_d   = pf_tag_q;
    pf_data_d  = pf_data_q;
    pend_tag_d = pend_tag_q;
    req_done_d = 1'b0;
    pf_hit_d   = 1'b0;
    req_line_d = req_line_q;
    fr_rd_d    = 1'b0;
    fr_tag_d   = fr_tag_q;
    unique case (state_q)
      IDLE: begin
        if (req_rd && idle_hit) begin
          req_done_d = 1'b1;
          pf_hit_d   = 1'b1;
          req_line_d = pf_data_q;
          pf_valid_d = 1'b0;
          if (pf_enable) begin
            fr_rd_d  = 1'b1;
            fr_tag_d = req_tag + 1'b1;
          end
        end else if (req_rd) begin
          fr_rd_d  = 1'b1;
          fr_tag_d = req_tag;
        end
      end
      DEMAND: begin
        if (fr_done) begin
          req_done_d = 1'b1;
          req_line_d = fr_line;
          if (pf_enable) begin
            fr_rd_d  = 1'b1;
            fr_tag_d = fr_tag_q + 1'b1;
          end
        end
      end
      PREFETCH, PF_PEND: begin
        if (fr_done) begin
          pf_kill_d = 1'b0;
          if (!kill) begin
            pf_valid_d = 1'b1;
            pf_tag_d   = fr_tag_q;
            pf_data_d  = fr_line;
          end
          if (resolve && res_hit) begin
            req_done_d = 1'b1;
            pf_hit_d   = 1'b1;
            req_line_d = fr_line;
            pf_valid_d = 1'b0;
            if (pf_enable) begin
              fr_rd_d  = 1'b1;
              fr_tag_d = fr_tag_q + 1'b1;
            end
          end else if (resolve) begin
            fr_rd_d  = 1'b1;
            fr_tag_d = res_tag;
          end
        end else if ((state_q == PREFETCH) && req_rd) begin
          pend_tag_d = req_tag;
        end
      end
      default: ;
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= IDLE;
      pf_valid_q <= 1'b0;
      pf_kill_q  <= 1'b0;
      req_done_q <= 1'b0;
      pf_hit_q   <= 1'b0;
      req_line_q <= '0;
      fr_rd_q    <= 1'b0;
      fr_tag_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
      state_q    <= state_d;
      pf_valid_q <= pf_valid_d;
      pf_kill_q  <= pf_kill_d;
      req_done_q <= req_done_d;
      pf_hit_q   <= pf_hit_d;
      req_line_q <= req_line_d;
      fr_rd_q    <= fr_rd_d;
      fr_tag_q   <= fr_tag_d;
    end
  end

  // Buffer payload and pending tag.
  // NOTE: no reset here; contents are only read when qualified by pf_valid_q or the FSM state.
  always_ff @(posedge HCLK) begin
    pf_tag_q   <= pf_tag_d;
    pf_data_q  <= pf_data_d;
    pend_tag_q <= pend_tag_d;
  end

  assign req_done = req_done_q;
  assign pf_hit   = pf_hit_q;
  assign req_line = req_line_q;
  assign fr_rd    = fr_rd_q;
  assign fr_addr  = {fr_tag_q, 4'h0};

endmodule
